// File: rtl/fnd_pkg.sv
// Shared constants for the 7-segment scan decoder: segment patterns, special codes, FSM states.
// Patterns are active-low with bit7 = dp.
package fnd_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DOT   = 8'h7F;

  localparam logic [3:0] CODE_BLANK = 4'd14;
  localparam logic [3:0] CODE_DOT   = 4'd15;
  localparam logic [3:0] CODE_MAXD  = 4'd9;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_DIGITS  = 2'd1,
    ST_OVERLAY = 2'd2
  } state_t;

  function automatic logic [6:0] pair_val(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

endpackage

// File: rtl/fnd_seg_decode.sv
// Combinational segment pattern to digit code decoder; zero latency.
// valid is low for any pattern outside the digit/blank/dot set.
module fnd_seg_decode
  import fnd_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [3:0] code,
  output logic       valid
);

  always_comb begin
    code  = 4'd0;
    valid = 1'b1;
    case (pattern)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      SEG_DOT:   code = CODE_DOT;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Recovers digits from a multiplexed 4-digit FND scan; alternating DIGITS/OVERLAY sweeps.
// Publishes one cycle after the accepted overlay pos3 capture; no backpressure (observe-only).
module fnd_scan_decoder
  import fnd_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int SLOT_TIMEOUT  = 200_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] fnd_com,
  input  logic [7:0] fnd_data,
  output logic [3:0] digit_1,
  output logic [3:0] digit_10,
  output logic [3:0] digit_100,
  output logic [3:0] digit_1000,
  output logic [6:0] o_lo,
  output logic [6:0] o_hi,
  output logic       dot,
  output logic       frame_valid,
  output logic       err,
  output logic       locked
);

  localparam int             SW        = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0]  STAB_FULL = SW'(STABLE_CYCLES);
  localparam logic [17:0]    TMO_FULL  = 18'(SLOT_TIMEOUT);
  localparam logic [17:0]    TMO_LAST  = 18'(SLOT_TIMEOUT - 1);

  logic [3:0]      slot_com;
  logic [7:0]      slot_data;
  logic [SW-1:0]   stab_cnt;
  logic [SW-1:0]   stab_next;
  logic            slot_done;
  logic [3:0]      com_q;
  logic [17:0]     tmo_cnt;

  logic            com_ok;
  logic [1:0]      cap_pos;
  logic            same;
  logic            done_eff;
  logic            cap;
  logic            com_chg;
  logic            tmo_hit;
  logic [3:0]      cap_code;
  logic            code_ok;

  state_t          state;
  logic [1:0]      exp_pos;
  logic [3:0][3:0] sh_dig;
  logic            sh_dot;
  logic            full_sweep;

  fnd_seg_decode u_dec (
    .pattern (fnd_data),
    .code    (cap_code),
    .valid   (code_ok)
  );

  always_comb begin
    com_ok  = 1'b1;
    cap_pos = 2'd0;
    case (fnd_com)
      4'b1110: cap_pos = 2'd0;
      4'b1101: cap_pos = 2'd1;
      4'b1011: cap_pos = 2'd2;
      4'b0111: cap_pos = 2'd3;
      default: com_ok  = 1'b0;
    endcase
  end

  // The tracker freezes while com is not a legal slot, so a blanking gap
  // neither restarts a captured slot nor lets it be captured twice.
  always_comb begin
    same      = (fnd_com == slot_com) && (fnd_data == slot_data);
    done_eff  = slot_done && (fnd_com == slot_com);
    stab_next = stab_cnt;
    if (!same)
      stab_next = SW'(1);
    else if (stab_cnt != STAB_FULL)
      stab_next = stab_cnt + SW'(1);
    cap     = com_ok && !done_eff && (stab_next == STAB_FULL);
    com_chg = (fnd_com != com_q);
    tmo_hit = !com_chg && (tmo_cnt == TMO_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_com  <= 4'hF;
      slot_data <= 8'hFF;
      stab_cnt  <= '0;
      slot_done <= 1'b0;
      com_q     <= 4'hF;
      tmo_cnt   <= '0;
    end else begin
      com_q <= fnd_com;
      if (com_chg)
        tmo_cnt <= '0;
      else if (tmo_cnt != TMO_FULL)
        tmo_cnt <= tmo_cnt + 18'd1;
      if (com_ok) begin
        slot_com  <= fnd_com;
        slot_data <= fnd_data;
        stab_cnt  <= stab_next;
        slot_done <= cap || done_eff;
      end
    end
  end

  assign locked = (state != ST_HUNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_HUNT;
      exp_pos     <= 2'd0;
      sh_dig      <= '0;
      sh_dot      <= 1'b0;
      full_sweep  <= 1'b0;
      digit_1     <= 4'd0;
      digit_10    <= 4'd0;
      digit_100   <= 4'd0;
      digit_1000  <= 4'd0;
      o_lo        <= 7'd0;
      o_hi        <= 7'd0;
      dot         <= 1'b0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      err         <= 1'b0;
      if (tmo_hit && state != ST_HUNT) begin
        err        <= 1'b1;
        state      <= ST_HUNT;
        exp_pos    <= 2'd0;
        sh_dig     <= '0;
        sh_dot     <= 1'b0;
        full_sweep <= 1'b0;
      end else if (cap) begin
        case (state)
          ST_HUNT: begin
            if (cap_pos == 2'd0 && code_ok) begin
              exp_pos    <= 2'd1;
              full_sweep <= 1'b0;
              if (cap_code <= CODE_MAXD) begin
                state     <= ST_DIGITS;
                sh_dig[0] <= cap_code;
              end else begin
                state <= ST_OVERLAY;
              end
            end
          end
          ST_DIGITS: begin
            if (cap_pos == exp_pos && code_ok && cap_code <= CODE_MAXD) begin
              sh_dig[exp_pos] <= cap_code;
              exp_pos         <= exp_pos + 2'd1;
              if (exp_pos == 2'd3) begin
                state      <= ST_OVERLAY;
                full_sweep <= 1'b1;
              end
            end else begin
              err        <= 1'b1;
              state      <= ST_HUNT;
              exp_pos    <= 2'd0;
              sh_dig     <= '0;
              sh_dot     <= 1'b0;
              full_sweep <= 1'b0;
            end
          end
          ST_OVERLAY: begin
            if (cap_pos == exp_pos && code_ok &&
                (cap_code == CODE_BLANK || (exp_pos == 2'd2 && cap_code == CODE_DOT))) begin
              exp_pos <= exp_pos + 2'd1;
              if (exp_pos == 2'd2)
                sh_dot <= (cap_code == CODE_DOT);
              if (exp_pos == 2'd3) begin
                state      <= ST_DIGITS;
                full_sweep <= 1'b0;
                if (full_sweep) begin
                  digit_1     <= sh_dig[0];
                  digit_10    <= sh_dig[1];
                  digit_100   <= sh_dig[2];
                  digit_1000  <= sh_dig[3];
                  o_lo        <= pair_val(sh_dig[1], sh_dig[0]);
                  o_hi        <= pair_val(sh_dig[3], sh_dig[2]);
                  dot         <= sh_dot;
                  frame_valid <= 1'b1;
                end
              end
            end else begin
              err        <= 1'b1;
              state      <= ST_HUNT;
              exp_pos    <= 2'd0;
              sh_dig     <= '0;
              sh_dot     <= 1'b0;
              full_sweep <= 1'b0;
            end
          end
          default: begin
            state   <= ST_HUNT;
            exp_pos <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Scoreboard bench for fnd_scan_decoder: expected frames queued as sweeps are driven,
// popped and compared when frame_valid pulses; scenario tasks check err/locked/hold behaviour.
module tb_fnd_scan_decoder;

  localparam int STAB = 16;
  localparam int TMO  = 1000;
  localparam int SLOT = 100;

  typedef struct packed {
    logic [3:0] d1000;
    logic [3:0] d100;
    logic [3:0] d10;
    logic [3:0] d1;
    logic [6:0] hi;
    logic [6:0] lo;
    logic       dt;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] fnd_com = 4'hF;
  logic [7:0] fnd_data = 8'hFF;
  logic [3:0] digit_1, digit_10, digit_100, digit_1000;
  logic [6:0] o_lo, o_hi;
  logic       dot, frame_valid, err, locked;

  int     checks = 0;
  int     errors = 0;
  int     fv_cnt = 0;
  int     err_cnt = 0;
  frame_t exp_q[$];
  frame_t last_pub = '0;

  fnd_scan_decoder #(.STABLE_CYCLES(STAB), .SLOT_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .fnd_com     (fnd_com),
    .fnd_data    (fnd_data),
    .digit_1     (digit_1),
    .digit_10    (digit_10),
    .digit_100   (digit_100),
    .digit_1000  (digit_1000),
    .o_lo        (o_lo),
    .o_hi        (o_hi),
    .dot         (dot),
    .frame_valid (frame_valid),
    .err         (err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  function automatic frame_t cur_out();
    return {digit_1000, digit_100, digit_10, digit_1, o_hi, o_lo, dot};
  endfunction

  function automatic logic [7:0] pat(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  default: return 8'h90;
    endcase
  endfunction

  always @(negedge clk) begin
    frame_t e;
    if (err) err_cnt++;
    if (frame_valid || err) begin
      checks++;
      if (frame_valid && err) begin
        errors++;
        $display("FAIL exclusive: frame_valid=%0b err=%0b, required not both high", frame_valid, err);
      end
    end
    if (frame_valid) begin
      fv_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame: got %h, required no frame", cur_out());
      end else begin
        e = exp_q.pop_front();
        last_pub = e;
        if (cur_out() !== e) begin
          errors++;
          $display("FAIL frame: got d=%0d%0d%0d%0d hi=%0d lo=%0d dot=%0b, required d=%0d%0d%0d%0d hi=%0d lo=%0d dot=%0b",
                   digit_1000, digit_100, digit_10, digit_1, o_hi, o_lo, dot,
                   e.d1000, e.d100, e.d10, e.d1, e.hi, e.lo, e.dt);
        end
      end
    end
  end

  task automatic slot(input int p, input logic [7:0] d, input int n, input int gap);
    fnd_com  = ~(4'b0001 << p);
    fnd_data = d;
    repeat (n) begin @(posedge clk); #1; end
    if (gap > 0) begin
      fnd_com  = 4'hF;
      fnd_data = 8'hFF;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic digit_sweep(input int d0, input int d1, input int d2, input int d3);
    slot(0, pat(d0), SLOT, 2);
    slot(1, pat(d1), SLOT, 2);
    slot(2, pat(d2), SLOT, 2);
    slot(3, pat(d3), SLOT, 2);
  endtask

  task automatic overlay_sweep(input bit dp);
    slot(0, 8'hFF, SLOT, 2);
    slot(1, 8'hFF, SLOT, 2);
    slot(2, dp ? 8'h7F : 8'hFF, SLOT, 2);
    slot(3, 8'hFF, SLOT, 2);
  endtask

  task automatic expect_frame(input int d0, input int d1, input int d2, input int d3, input bit dp);
    frame_t f;
    f.d1 = 4'(d0); f.d10 = 4'(d1); f.d100 = 4'(d2); f.d1000 = 4'(d3);
    f.lo = 7'(d1 * 10 + d0);
    f.hi = 7'(d3 * 10 + d2);
    f.dt = dp;
    exp_q.push_back(f);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_int("rst_digits", {digit_1000, digit_100, digit_10, digit_1}, 0);
    check_int("rst_o_lo", o_lo, 0);
    check_int("rst_o_hi", o_hi, 0);
    check_int("rst_dot", dot, 0);
    check_int("rst_frame_valid", frame_valid, 0);
    check_int("rst_err", err, 0);
    check_int("rst_locked", locked, 0);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    int fv0 = fv_cnt, e0 = err_cnt;
    digit_sweep(4, 3, 2, 1);
    check_int("basic_no_early_frame", fv_cnt - fv0, 0);
    check_int("basic_locked_digits", locked, 1);
    expect_frame(4, 3, 2, 1, 1'b1);
    overlay_sweep(1'b1);
    check_int("basic_frames", fv_cnt - fv0, 1);
    check_int("basic_errs", err_cnt - e0, 0);
    check_int("basic_o_lo", o_lo, 34);
    check_int("basic_o_hi", o_hi, 12);
    check_int("basic_dot", dot, 1);
    check_int("basic_locked", locked, 1);
  endtask

  task automatic test_back_to_back();
    int fv0 = fv_cnt, e0 = err_cnt;
    digit_sweep(9, 0, 7, 5);
    expect_frame(9, 0, 7, 5, 1'b0);
    overlay_sweep(1'b0);
    digit_sweep(9, 9, 9, 9);
    expect_frame(9, 9, 9, 9, 1'b1);
    overlay_sweep(1'b1);
    digit_sweep(0, 0, 0, 0);
    expect_frame(0, 0, 0, 0, 1'b0);
    overlay_sweep(1'b0);
    check_int("b2b_frames", fv_cnt - fv0, 3);
    check_int("b2b_errs", err_cnt - e0, 0);
  endtask

  task automatic test_bad_pattern();
    int fv0 = fv_cnt, e0 = err_cnt;
    slot(0, pat(6), SLOT, 2);
    slot(1, 8'h00, SLOT, 2);
    check_int("badpat_err", err_cnt - e0, 1);
    check_int("badpat_locked", locked, 0);
    checks++;
    if (cur_out() !== last_pub) begin
      errors++;
      $display("FAIL badpat_hold: got %h, required %h", cur_out(), last_pub);
    end
    slot(2, pat(1), SLOT, 2);
    slot(3, pat(2), SLOT, 2);
    check_int("badpat_hunt_silent", err_cnt - e0, 1);
    check_int("badpat_frames", fv_cnt - fv0, 0);
  endtask

  task automatic test_overlay_start();
    int fv0 = fv_cnt, e0 = err_cnt;
    overlay_sweep(1'b1);
    check_int("ovstart_no_frame", fv_cnt - fv0, 0);
    check_int("ovstart_locked", locked, 1);
    digit_sweep(8, 1, 3, 7);
    expect_frame(8, 1, 3, 7, 1'b0);
    overlay_sweep(1'b0);
    check_int("ovstart_frames", fv_cnt - fv0, 1);
    check_int("ovstart_errs", err_cnt - e0, 0);
  endtask

  task automatic test_wrong_pos();
    int e0 = err_cnt;
    slot(0, pat(1), SLOT, 2);
    slot(1, pat(2), SLOT, 2);
    check_int("wrongpos_no_err_yet", err_cnt - e0, 0);
    slot(3, pat(4), SLOT, 2);
    check_int("wrongpos_err", err_cnt - e0, 1);
    check_int("wrongpos_locked", locked, 0);
  endtask

  task automatic test_glitch();
    int fv0 = fv_cnt, e0 = err_cnt;
    slot(0, pat(6), SLOT, 2);
    slot(1, pat(5), 50, 0);
    slot(1, 8'h80, 5, 0);
    slot(1, pat(5), 45, 2);
    slot(2, pat(0), SLOT, 2);
    slot(3, pat(2), SLOT, 2);
    expect_frame(6, 5, 0, 2, 1'b1);
    overlay_sweep(1'b1);
    check_int("glitch_frames", fv_cnt - fv0, 1);
    check_int("glitch_errs", err_cnt - e0, 0);
  endtask

  task automatic test_timeout();
    int fv0 = fv_cnt, e0 = err_cnt;
    slot(0, pat(3), SLOT, 2);
    slot(1, pat(3), SLOT, 2);
    slot(2, pat(3), TMO - 50, 0);
    check_int("tmo_not_yet", err_cnt - e0, 0);
    check_int("tmo_locked_before", locked, 1);
    slot(2, pat(3), 100, 2);
    check_int("tmo_err", err_cnt - e0, 1);
    check_int("tmo_locked_after", locked, 0);
    check_int("tmo_frames", fv_cnt - fv0, 0);
    checks++;
    if (cur_out() !== last_pub) begin
      errors++;
      $display("FAIL tmo_hold: got %h, required %h", cur_out(), last_pub);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int fv0, e0;
    digit_sweep(1, 2, 3, 4);
    expect_frame(1, 2, 3, 4, 1'b1);
    overlay_sweep(1'b1);
    fv0 = fv_cnt; e0 = err_cnt;
    digit_sweep(5, 6, 7, 8);
    slot(0, 8'hFF, SLOT, 2);
    slot(1, 8'hFF, 40, 0);
    reset = 1'b0;
    #1;
    check_int("rstmid_digits", {digit_1000, digit_100, digit_10, digit_1}, 0);
    check_int("rstmid_o_lo_hi", {o_hi, o_lo}, 0);
    check_int("rstmid_dot", dot, 0);
    check_int("rstmid_locked", locked, 0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    slot(1, 8'hFF, 60, 2);
    slot(2, 8'h7F, SLOT, 2);
    slot(3, 8'hFF, SLOT, 2);
    check_int("rstmid_no_frame", fv_cnt - fv0, 0);
    overlay_sweep(1'b0);
    check_int("rstmid_overlay_only", fv_cnt - fv0, 0);
    digit_sweep(5, 6, 7, 8);
    expect_frame(5, 6, 7, 8, 1'b0);
    overlay_sweep(1'b0);
    check_int("rstmid_frames", fv_cnt - fv0, 1);
    check_int("rstmid_errs", err_cnt - e0, 0);
  endtask

  task automatic test_drain();
    check_int("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_bad_pattern();
    test_overlay_start();
    test_wrong_pos();
    test_glitch();
    test_timeout();
    test_reset_mid_sweep();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
